// File: rtl/rom_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_reader_pkg
// Description : Shared defaults, burst-length limits, FSM state type and a
//               length-clamp helper for the ROM burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_reader_pkg;

    localparam int ROM_DEPTH  = 8;
    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 4;

    localparam int LEN_W   = 4;
    localparam int MAX_LEN = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A burst can never exceed the ROM size, so oversize requests saturate.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_reader_if
// Description : Bundles the burst-control, ROM and output-stream signals of
//               the ROM burst reader.
//   Control : start, base_addr, len, abort (to reader); busy, done (from)
//   ROM     : rom_addr (from reader), rom_data (to reader, combinational)
//   Stream  : out_valid, out_data, out_last (from reader); out_ready (to)
//   master modport = requester / ROM / sink side, slave modport = reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_reader_if
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output start, base_addr, len, abort, rom_data, out_ready,
        input  busy, done, rom_addr, out_valid, out_data, out_last
    );

    modport slave (
        input  start, base_addr, len, abort, rom_data, out_ready,
        output busy, done, rom_addr, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/rom_reader.sv
`default_nettype none
// ============================================================================
// Module      : rom_reader
// Description : Reads a burst of consecutive words from a combinational ROM
//               and streams them out over a valid/ready interface with a
//               single output register.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rom_reader_if.slave (control, ROM port, output stream)
// Revision    : 1.0 - initial release
// ============================================================================
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int DEPTH  = ROM_DEPTH,
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  wire          clk,
    input  wire          rst_n,
    rom_reader_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q,     state_d;
    logic [IDX_W-1:0]  cur_addr_q,  cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic              done_q,      done_d;

    logic [LEN_W-1:0]  len_eff;
    logic [ADDR_W-1:0] base_mod;
    logic [IDX_W-1:0]  next_addr;
    logic              slot_free;

    assign len_eff   = clamp_len(bus.len);
    assign base_mod  = bus.base_addr % ADDR_W'(DEPTH);
    assign next_addr = (cur_addr_q == IDX_W'(DEPTH - 1)) ? '0
                                                         : cur_addr_q + IDX_W'(1);
    // The output register may take a new word when empty or being drained.
    assign slot_free = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (bus.abort) begin
            // Cancel outranks start and any handshake; no completion pulse.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (len_eff != '0) begin
                            cur_addr_d  = IDX_W'(base_mod);
                            remaining_d = len_eff;
                            state_d     = ST_FETCH;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (slot_free) begin
                        out_data_d  = bus.rom_data;
                        out_valid_d = 1'b1;
                        out_last_d  = (remaining_q == LEN_W'(1));
                        cur_addr_d  = next_addr;
                        remaining_d = remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign bus.rom_addr  = ADDR_W'(cur_addr_q);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_reader
// Description : Directed self-checking bench for rom_reader, attached to an
//               8x4 ROM image whose word i holds 2*i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_reader;
    import rom_reader_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] ROM_IMG [8] = '{4'd0, 4'd2, 4'd4, 4'd6,
                                           4'd8, 4'd10, 4'd12, 4'd14};
    localparam logic [3:0] EXP_WRAP [4] = '{4'd12, 4'd14, 4'd0, 4'd2};
    localparam logic [3:0] EXP_CLAMP [8] = '{4'd6, 4'd8, 4'd10, 4'd12,
                                            4'd14, 4'd0, 4'd2, 4'd4};

    rom_reader_if #(.ADDR_W(ROM_ADDR_W), .DATA_W(ROM_DATA_W)) bus ();

    rom_reader #(
        .DEPTH  (ROM_DEPTH),
        .ADDR_W (ROM_ADDR_W),
        .DATA_W (ROM_DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Out-of-range addresses read 0xF so a bad upper address bit shows up.
    assign bus.rom_data = (bus.rom_addr < 8'd8) ? ROM_IMG[bus.rom_addr[2:0]] : 4'hF;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {out_valid, out_last, out_data} against a valid beat
    task automatic chk_beat(input string tag, input logic [3:0] d, input logic l);
        chk(tag, {26'd0, bus.out_valid, bus.out_last, bus.out_data}, {26'd0, 1'b1, l, d});
    endtask

    // {out_valid, busy, done}
    task automatic chk_ctl(input string tag, input logic v, input logic b, input logic dn);
        chk(tag, {29'd0, bus.out_valid, bus.busy, bus.done}, {29'd0, v, b, dn});
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {16'd0, bus.rom_addr, bus.out_valid, bus.out_data, bus.out_last,
                  bus.busy, bus.done}, 32'd0);
    endtask

    task automatic do_start(input logic [7:0] base, input logic [3:0] n);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.len       = n;
        tick();
        bus.start     = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk_all_zero("reset_outputs");
        tick();
        tick();
        chk_all_zero("reset_held");
        rst_n = 1'b1;

        // Full 8-word burst, sink always ready
        bus.out_ready = 1'b1;
        do_start(8'd0, 4'd8);
        chk_ctl("t1_fetch_ctl", 1'b0, 1'b1, 1'b0);
        chk("t1_rom_addr", {24'd0, bus.rom_addr}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_beat($sformatf("t1_beat%0d", k), 4'(2 * k), k == 7);
            chk_ctl($sformatf("t1_ctl%0d", k), 1'b1, 1'b1, 1'b0);
        end
        tick();
        chk_ctl("t1_done", 1'b0, 1'b0, 1'b1);
        tick();
        chk_ctl("t1_idle", 1'b0, 1'b0, 1'b0);

        // Wrap-around; upper base bits ignored
        do_start(8'hE6, 4'd4);
        chk("t2_rom_addr", {24'd0, bus.rom_addr}, 32'd6);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_beat($sformatf("t2_beat%0d", k), EXP_WRAP[k], k == 3);
        end
        tick();
        chk_ctl("t2_done", 1'b0, 1'b0, 1'b1);

        // Back-pressure on the second beat
        do_start(8'd1, 4'd3);
        tick();
        chk_beat("t3_beat2", 4'd2, 1'b0);
        tick();
        chk_beat("t3_beat4", 4'd4, 1'b0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_beat($sformatf("t3_hold%0d", k), 4'd4, 1'b0);
            chk($sformatf("t3_hold_addr%0d", k), {24'd0, bus.rom_addr}, 32'd3);
        end
        bus.out_ready = 1'b1;
        tick();
        chk_beat("t3_beat6", 4'd6, 1'b1);
        tick();
        chk_ctl("t3_done", 1'b0, 1'b0, 1'b1);
        tick();
        chk_ctl("t3_done_once", 1'b0, 1'b0, 1'b0);

        // Zero-length request
        do_start(8'd3, 4'd0);
        chk_ctl("t4_done", 1'b0, 1'b0, 1'b1);
        tick();
        chk_ctl("t4_idle", 1'b0, 1'b0, 1'b0);

        // Oversize length saturates at 8
        do_start(8'd3, 4'd15);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_beat($sformatf("t5_beat%0d", k), EXP_CLAMP[k], k == 7);
        end
        tick();
        chk_ctl("t5_done", 1'b0, 1'b0, 1'b1);

        // Start while busy is ignored, then abort
        do_start(8'd0, 4'd8);
        tick();
        tick();
        chk_beat("t6_beat2", 4'd2, 1'b0);
        do_start(8'd5, 4'd2);
        chk_beat("t6_start_ignored", 4'd4, 1'b0);
        tick();
        chk_beat("t6_beat6", 4'd6, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_ctl("t6_abort", 1'b0, 1'b0, 1'b0);
        chk("t6_abort_last", {31'd0, bus.out_last}, 32'd0);
        tick();
        chk_ctl("t6_no_done", 1'b0, 1'b0, 1'b0);
        bus.abort = 1'b1;
        do_start(8'd0, 4'd2);
        bus.abort = 1'b0;
        chk_ctl("t6_abort_over_start", 1'b0, 1'b0, 1'b0);
        do_start(8'd2, 4'd2);
        chk_ctl("t6_new_fetch", 1'b0, 1'b1, 1'b0);
        tick();
        chk_beat("t6_new_beat4", 4'd4, 1'b0);
        tick();
        chk_beat("t6_new_beat6", 4'd6, 1'b1);
        tick();
        chk_ctl("t6_new_done", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-burst
        do_start(8'd0, 4'd8);
        tick();
        tick();
        chk_beat("t7_beat2", 4'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("t7_async_reset");
        tick();
        chk_all_zero("t7_reset_held");
        rst_n = 1'b1;
        do_start(8'd5, 4'd2);
        chk_ctl("t7_fetch", 1'b0, 1'b1, 1'b0);
        chk("t7_rom_addr", {24'd0, bus.rom_addr}, 32'd5);
        tick();
        chk_beat("t7_beat10", 4'd10, 1'b0);
        tick();
        chk_beat("t7_beat12", 4'd12, 1'b1);
        tick();
        chk_ctl("t7_done", 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
